luma_cost_feeder: RTL and testbench
===================================

Name: luma_cost_feeder

Overview:
- Initiator/front end for the 16x16 luma cost unit (sum-of-squares over 16 AC blocks plus a 16-entry DC vector).
- Accepts a macroblock as 16 serially streamed 4x4 coefficient blocks and assembles the wide ac/dc buses.
- Optionally splits each block's coefficient 0 into the DC vector, pulses the cost unit's start, holds the buses stable until done, and returns the 32-bit cost through a valid/ready output.

Parameters:
- BIT_WIDTH, 16, width of one signed coefficient
- BLOCK_SIZE, 16, 4x4 blocks per macroblock; also coefficients per block

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  feeder can accept a block
- in_coef  in  BIT_WIDTH*BLOCK_SIZE  one 4x4 block; coefficient j at bits [16j+15:16j]
- in_split_dc  in  1  DC-split mode; sampled with block 0 only
- abort  in  1  synchronous flush of the current macroblock
- cost_start  out  1  one-cycle start pulse to the cost unit
- cost_ac  out  BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE  AC bus; block i at bits [256(i+1)-1:256i]
- cost_dc  out  BIT_WIDTH*BLOCK_SIZE  DC bus; entry i at bits [16(i+1)-1:16i]
- cost_sum  in  32  cost result
- cost_done  in  1  cost result valid (one-cycle pulse)
- out_valid  out  1  result valid
- out_sum  out  32  macroblock cost
- out_ready  in  1  downstream accepts the result

Behaviour:
- Reset: all outputs, registers and buffers are 0 (in_ready=0, cost_start=0, cost_ac=0, cost_dc=0, out_valid=0, out_sum=0). The FSM enters FILL. in_ready rises on the first cycle after reset release.
- Clock and reset: rst_n is asynchronous, active-low; clk is the only clock.
- FSM states: FILL, KICK, WAIT, OUT.
- FILL:
  - in_ready=1. A block is accepted on in_valid&in_ready.
  - A 4-bit blk counter (0..15) selects the buffer slot.
  - On blk==0, in_split_dc is latched into split_r.
  - split_r=1: cost_dc[blk] <= coef0, and cost_ac block blk is stored with coefficient 0 forced to 0.
  - split_r=0: the block is stored unchanged and cost_dc[blk] <= 0.
  - Accepting blk==15 wraps blk to 0 and moves to KICK.
- KICK: in_ready=0; cost_start=1 for exactly this one cycle; next state WAIT.
- WAIT:
  - in_ready=0; cost_ac and cost_dc are held unchanged.
  - On cost_done: out_sum <= cost_sum, next state OUT.
  - The cost unit's done arrives 18 cycles after start; no timeout is applied.
- OUT:
  - out_valid=1, out_sum stable.
  - On out_ready: out_valid falls next cycle and the FSM returns to FILL.
  - in_ready stays 0 while in OUT (no overlap with the next macroblock).
- Latency: accepting block 15 in cycle N gives cost_start in N+1 and out_valid in D+1, where D is the cost_done cycle.
- cost_done outside WAIT: ignored, no state change.
- abort:
  - In FILL: blk is cleared to 0; buffers need not be cleared.
  - In KICK or WAIT: ignored, so the cost unit is never left with unstable buses.
  - In OUT: out_valid is dropped and the FSM returns to FILL.
  - abort together with an accepted block in FILL: abort wins and the block is discarded.
- Only block 0 samples in_split_dc; changes on blocks 1..15 have no effect.
- Arithmetic: no arithmetic on coefficients; pure routing. out_sum is passed through unmodified, and 32-bit wrap is the cost unit's responsibility.
- Reset mid-macroblock: everything clears immediately; a pending result is lost.

Test Plan:
- Split ramp: 16 blocks, each coefficient j = j+1, split=1 -> cost_dc all 1, AC coefficient 0 of every block = 0; with a behavioural cost model, out_sum = 16 + 16*1495 = 23936; exactly one cost_start pulse.
- No-split ramp: same data, split=0 -> cost_dc all 0, AC unchanged; out_sum = 16*1496 = 23936; split toggled on blocks 1..15 has no effect.
- Negative values: all coefficients -3, split=1 -> cost_dc entries 0xFFFD; out_sum = 2304.
- Backpressure: in_valid gapped randomly, out_ready held low 10 cycles -> out_valid and out_sum stable throughout; in_ready=0 from KICK until the cycle after the OUT handshake; cost_ac unchanged during WAIT.
- abort after 7 blocks, then a full macroblock of ones with split=0 -> the result reflects only the new macroblock (out_sum = 256); abort asserted during WAIT is ignored.
- Stray cost_done pulsed in FILL -> no out_valid. rst_n pulsed low in WAIT -> all outputs 0, and the FSM resumes in FILL.

Source files
------------

// File: rtl/luma_cost_feeder.sv
// luma_cost_feeder
// ----------------
// Front end for the 16x16 luma cost unit. Takes a macroblock as BLOCK_SIZE
// serially streamed 4x4 coefficient blocks and assembles the wide AC/DC buses.
// In DC-split mode it moves each block's coefficient 0 into the DC vector.
// It pulses cost_start once, holds both buses stable until cost_done, and
// returns the 32-bit cost through a valid/ready output.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     input block valid
//   in_ready     feeder can accept a block (FILL only)
//   in_coef      one 4x4 block, coefficient j at [BIT_WIDTH*j +: BIT_WIDTH]
//   in_split_dc  DC-split mode, sampled with block 0 only
//   abort        synchronous flush of the macroblock being filled or returned
//   cost_start   one-cycle start pulse to the cost unit
//   cost_ac      AC bus, block i at [BIT_WIDTH*BLOCK_SIZE*i +: BIT_WIDTH*BLOCK_SIZE]
//   cost_dc      DC bus, entry i at [BIT_WIDTH*i +: BIT_WIDTH]
//   cost_sum     cost unit result
//   cost_done    cost unit result valid (one-cycle pulse)
//   out_valid    result valid
//   out_sum      macroblock cost
//   out_ready    downstream accepts the result
module luma_cost_feeder #(
  parameter int BIT_WIDTH  = 16,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]       in_coef,
  input  logic                                  in_split_dc,
  input  logic                                  abort,
  output logic                                  cost_start,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] cost_ac,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]       cost_dc,
  input  logic [31:0]                           cost_sum,
  input  logic                                  cost_done,
  output logic                                  out_valid,
  output logic [31:0]                           out_sum,
  input  logic                                  out_ready
);

  localparam int BLK_W = BIT_WIDTH * BLOCK_SIZE;
  localparam int AC_W  = BLK_W * BLOCK_SIZE;
  localparam int CNT_W = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {
    S_FILL,
    S_KICK,
    S_WAIT,
    S_OUT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_blk;
  logic                r_split;
  logic                r_in_ready;
  logic [AC_W-1:0]     r_ac;
  logic [BLK_W-1:0]    r_dc;
  logic [31:0]         r_out_sum;

  logic                w_accept;
  logic                w_split;
  logic                w_last;
  logic [BLK_W-1:0]    w_blk_store;
  logic [BIT_WIDTH-1:0] w_dc_store;

  // abort in FILL wins over a simultaneous block: the block is dropped.
  assign w_accept = (r_state == S_FILL) && in_valid && r_in_ready && !abort;
  assign w_last   = (r_blk == CNT_W'(BLOCK_SIZE - 1));

  // Block 0 uses the live split flag; later blocks use the value latched with it.
  assign w_split  = (r_blk == '0) ? in_split_dc : r_split;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_blk_store = in_coef;
    w_dc_store  = '0;
    if (w_split) begin
      w_blk_store[BIT_WIDTH-1:0] = '0;
      w_dc_store                 = in_coef[BIT_WIDTH-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL:  if (w_accept && w_last) w_next = S_KICK;
      S_KICK:  w_next = S_WAIT;
      // abort is deliberately not looked at in KICK/WAIT so the cost unit
      // always sees stable buses for the whole computation.
      S_WAIT:  if (cost_done) w_next = S_OUT;
      S_OUT:   if (out_ready || abort) w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      // Registered from the next state: low during reset, high on the first
      // cycle after release, low from KICK until the cycle after the OUT handshake.
      r_in_ready <= (w_next == S_FILL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk   <= '0;
      r_split <= 1'b0;
    end else if (r_state == S_FILL) begin
      if (abort) begin
        r_blk <= '0;
      end else if (w_accept) begin
        r_blk <= w_last ? '0 : r_blk + 1'b1;
        if (r_blk == '0) r_split <= in_split_dc;
      end
    end
  end

  // NOTE: the bus buffers are wide, but they are reset because the cost unit
  // and downstream must see all-zero buses after reset, not stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ac <= '0;
      r_dc <= '0;
    end else if (w_accept) begin
      r_ac[r_blk*BLK_W +: BLK_W]         <= w_blk_store;
      r_dc[r_blk*BIT_WIDTH +: BIT_WIDTH] <= w_dc_store;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_sum <= '0;
    end else if (r_state == S_WAIT && cost_done) begin
      r_out_sum <= cost_sum;
    end
  end

  assign in_ready   = r_in_ready;
  assign cost_start = (r_state == S_KICK);
  assign cost_ac    = r_ac;
  assign cost_dc    = r_dc;
  assign out_valid  = (r_state == S_OUT);
  assign out_sum    = r_out_sum;

endmodule

// File: tb/tb_luma_cost_feeder.sv
// Testbench for luma_cost_feeder: streams macroblocks, models the cost unit
// (sum of squares, done 18 cycles after start) and compares buses, handshakes
// and results against expectations derived from the stimulus blocks.
module tb_luma_cost_feeder;

  localparam int BW    = 16;
  localparam int BS    = 16;
  localparam int BLK_W = BW * BS;
  localparam int AC_W  = BLK_W * BS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [BLK_W-1:0]  in_coef;
  logic              in_split_dc;
  logic              abort;
  logic              cost_start;
  logic [AC_W-1:0]   cost_ac;
  logic [BLK_W-1:0]  cost_dc;
  logic [31:0]       cost_sum;
  logic              cost_done;
  logic              out_valid;
  logic [31:0]       out_sum;
  logic              out_ready;

  logic              model_done;
  logic              stray_done;
  int                pend;
  logic [31:0]       model_result;

  int checks = 0;
  int errors = 0;

  logic [BLK_W-1:0]  blk_data [BS];
  bit                exp_split;

  luma_cost_feeder #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .in_split_dc(in_split_dc), .abort(abort),
    .cost_start(cost_start), .cost_ac(cost_ac), .cost_dc(cost_dc),
    .cost_sum(cost_sum), .cost_done(cost_done),
    .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  assign cost_done = model_done | stray_done;

  // Behavioural cost unit: squares every AC coefficient and DC entry present
  // on the buses at start, answers 18 cycles later.
  function automatic logic [31:0] bus_cost(input logic [AC_W-1:0] ac, input logic [BLK_W-1:0] dc);
    int s = 0;
    int v;
    for (int k = 0; k < BS * BS; k++) begin
      v = $signed(ac[k*BW +: BW]);
      s += v * v;
    end
    for (int k = 0; k < BS; k++) begin
      v = $signed(dc[k*BW +: BW]);
      s += v * v;
    end
    return 32'(s);
  endfunction

  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          model_done = 1'b1;
          cost_sum   = model_result;
        end
      end
      if (cost_start) begin
        pend         = 18;
        model_result = bus_cost(cost_ac, cost_dc);
      end
    end
  end

  // Expected values straight from the stimulus blocks.
  function automatic logic [AC_W-1:0] exp_ac();
    logic [BLK_W-1:0] b;
    logic [AC_W-1:0]  bus = '0;
    for (int i = 0; i < BS; i++) begin
      b = blk_data[i];
      if (exp_split) b[BW-1:0] = '0;
      bus[i*BLK_W +: BLK_W] = b;
    end
    return bus;
  endfunction

  function automatic logic [BLK_W-1:0] exp_dc();
    logic [BLK_W-1:0] bus = '0;
    logic [BLK_W-1:0] b;
    for (int i = 0; i < BS; i++) begin
      b = blk_data[i];
      if (exp_split) bus[i*BW +: BW] = b[BW-1:0];
    end
    return bus;
  endfunction

  // Splitting only moves coefficient 0, so the cost is always the plain sum
  // of squares over all 256 stimulus coefficients.
  function automatic logic [31:0] exp_sum();
    int s = 0;
    int v;
    logic [BLK_W-1:0] b;
    for (int i = 0; i < BS; i++) begin
      b = blk_data[i];
      for (int j = 0; j < BS; j++) begin
        v = $signed(b[j*BW +: BW]);
        s += v * v;
      end
    end
    return 32'(s);
  endfunction

  task automatic fill_const(input logic [BW-1:0] val);
    for (int i = 0; i < BS; i++)
      for (int j = 0; j < BS; j++) blk_data[i][j*BW +: BW] = val;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < BS; i++)
      for (int j = 0; j < BS; j++) blk_data[i][j*BW +: BW] = 16'(j + 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BS; i++)
      for (int j = 0; j < BS; j++) blk_data[i][j*BW +: BW] = 16'($urandom);
  endtask

  // Offers blocks 0..n-1; returns at the negedge after the last acceptance.
  task automatic send_blocks(input int n, input bit split0, input bit toggle, input bit gaps);
    int  t;
    bit  acc;
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid    = 1'b1;
      in_coef     = blk_data[b];
      in_split_dc = (b == 0 || !toggle) ? split0 : 1'($urandom_range(0, 1));
      t = 0;
      forever begin
        acc = in_ready;
        @(negedge clk);
        if (acc) break;
        if (++t > 50) begin
          checks++; errors++;
          $display("FAIL accept_timeout block %0d: in_ready stayed 0, required 1", b);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Called at the negedge of the KICK cycle; follows the macroblock to the
  // output handshake.
  task automatic finish_mb(input int hold, input bit abort_in_wait);
    logic [AC_W-1:0] snap;
    int  n = 0;
    int  starts;
    bit  unstable = 0;
    bit  rdy_bad = 0;
    bit  hold_bad = 0;
    logic [31:0] want = exp_sum();

    checks++;
    if (cost_start !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL kick: cost_start=%b in_ready=%b, required 1/0", cost_start, in_ready);
    end
    checks++;
    if (cost_ac !== exp_ac()) begin
      errors++;
      $display("FAIL ac_bus: got %h.. required %h..", cost_ac[511:0], exp_ac() & {{(AC_W-512){1'b0}}, {512{1'b1}}});
    end
    checks++;
    if (cost_dc !== exp_dc()) begin
      errors++;
      $display("FAIL dc_bus: got %h required %h", cost_dc, exp_dc());
    end

    snap   = cost_ac;
    starts = 1;
    while (!out_valid && n < 100) begin
      abort = (abort_in_wait && n == 3);
      @(negedge clk);
      n++;
      if (cost_start) starts++;
      if (cost_ac !== snap) unstable = 1;
      if (in_ready) rdy_bad = 1;
    end
    abort = 1'b0;

    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout: out_valid=0 after %0d cycles, required 1", n);
      return;
    end
    checks++;
    if (n != 19) begin
      errors++;
      $display("FAIL latency: out_valid %0d cycles after start, required 19", n);
    end
    checks++;
    if (out_sum !== want) begin
      errors++;
      $display("FAIL out_sum: got %0d required %0d", out_sum, want);
    end
    checks++;
    if (starts != 1 || unstable || rdy_bad) begin
      errors++;
      $display("FAIL wait_phase: starts=%0d unstable=%0d in_ready_high=%0d, required 1/0/0",
               starts, unstable, rdy_bad);
    end

    repeat (hold) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== want || in_ready !== 1'b0) hold_bad = 1;
    end
    if (hold > 0) begin
      checks++;
      if (hold_bad) begin
        errors++;
        $display("FAIL out_hold: out_valid/out_sum/in_ready changed under backpressure, required stable 1/%0d/0", want);
      end
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic run_mb(input bit split0, input bit toggle, input bit gaps,
                        input int hold, input bit abort_in_wait);
    exp_split = split0;
    send_blocks(BS, split0, toggle, gaps);
    finish_mb(hold, abort_in_wait);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_coef = '0; in_split_dc = 1'b0;
    abort = 1'b0; out_ready = 1'b0; stray_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || cost_start !== 1'b0 || cost_ac !== '0 || cost_dc !== '0 ||
        out_valid !== 1'b0 || out_sum !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b start=%b out_valid=%b out_sum=%0d, required all 0",
               in_ready, cost_start, out_valid, out_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_split_ramp();
    fill_ramp();
    run_mb(1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_nosplit_ramp();
    fill_ramp();
    run_mb(1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_negative();
    fill_const(16'hFFFD);
    run_mb(1'b1, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      fill_random();
      run_mb(1'($urandom_range(0, 1)), 1'b1, 1'b1, 10, 1'b0);
    end
  endtask

  task automatic test_abort();
    fill_random();
    exp_split = 1'b1;
    send_blocks(7, 1'b1, 1'b0, 1'b1);
    // abort together with an offered block: the block must be discarded
    in_valid = 1'b1;
    in_coef  = blk_data[7];
    abort    = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    fill_const(16'h0001);
    run_mb(1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_stray_done();
    bit seen = 0;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_done: out_valid_seen=%0d in_ready=%b, required 0/1", seen, in_ready);
    end
  endtask

  task automatic test_abort_out();
    int n = 0;
    fill_random();
    exp_split = 1'b0;
    send_blocks(BS, 1'b0, 1'b0, 1'b0);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL abort_out_timeout: out_valid=0, required 1");
      return;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_out: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen = 0;
    fill_random();
    exp_split = 1'b1;
    send_blocks(BS, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || cost_start !== 1'b0 || cost_ac !== '0 || cost_dc !== '0 ||
        out_valid !== 1'b0 || out_sum !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_wait: in_ready=%b start=%b out_valid=%b out_sum=%0d, required all 0",
               in_ready, cost_start, out_valid, out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL resume_fill: out_valid_seen=%0d in_ready=%b, required 0/1", seen, in_ready);
    end
    fill_random();
    run_mb(1'($urandom_range(0, 1)), 1'b1, 1'b1, 2, 1'b0);
  endtask

  initial begin
    model_done = 1'b0;
    cost_sum   = '0;
    pend       = 0;
    test_reset();
    test_split_ramp();
    test_nosplit_ramp();
    test_negative();
    test_backpressure();
    test_abort();
    test_stray_done();
    test_abort_out();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
